// File: rtl/dct_pkg.sv
// dct_pkg: shared widths, FSM states and add/sub op codes for the DCT stage-1 butterfly.
package dct_pkg;
  localparam int W  = 16;
  localparam int N  = 8;
  localparam int IW = $clog2(N);
  typedef enum logic [1:0] {LOAD, CALC, DRAIN} state_t;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/dct_addsub16.sv
// dct_addsub16: shared two's complement adder/subtractor with signed overflow flag.
module dct_addsub16
  import dct_pkg::*;
(
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_op,
  output logic [W-1:0] o_r,
  output logic         o_ovf
);
  logic [W-1:0] w_b;
  assign w_b   = (i_op == OP_SUB) ? ~i_b : i_b;
  assign o_r   = i_a + w_b + W'(i_op);
  assign o_ovf = (i_a[W-1] == w_b[W-1]) && (o_r[W-1] != i_a[W-1]);
endmodule

// File: rtl/dct_butterfly_sched.sv
// dct_butterfly_sched: buffers one 8-sample frame, then issues 4 sums and 4 differences
// through a single shared add/sub unit, one registered result per cycle.
module dct_butterfly_sched
  import dct_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic [IW-1:0] out_idx,
  output logic          out_ovf,
  output logic          busy
);
  state_t        r_state;
  logic [IW-1:0] r_lcnt, r_opcnt;
  logic [W-1:0]  r_x [N];
  logic          r_out_valid, r_out_ovf;
  logic [W-1:0]  r_out_data;
  logic [IW-1:0] r_out_idx;
  logic          w_load, w_issue, w_ovf;
  logic [IW-1:0] w_j, w_jb;
  logic [W-1:0]  w_r;
  assign in_ready  = r_state == LOAD;
  assign busy      = r_state == CALC;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_idx   = r_out_idx;
  assign out_ovf   = r_out_ovf;
  assign w_load    = in_valid && r_state == LOAD;
  assign w_issue   = r_state == CALC && (!r_out_valid || out_ready);
  // k and k+N/2 share operand pair j; N-1-j is the bitwise inverse of j since N is a power of 2
  assign w_j  = {1'b0, r_opcnt[IW-2:0]};
  assign w_jb = ~w_j;
  dct_addsub16 u_addsub (
    .i_a  (r_x[w_j]),
    .i_b  (r_x[w_jb]),
    .i_op (r_opcnt[IW-1]),
    .o_r  (w_r),
    .o_ovf(w_ovf)
  );
  always_ff @(posedge clk) begin
    if (w_load) r_x[r_lcnt] <= in_data;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= LOAD;
      r_lcnt      <= '0;
      r_opcnt     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_idx   <= '0;
      r_out_ovf   <= 1'b0;
    end else begin
      if (w_load) begin
        r_lcnt <= r_lcnt + 1'b1;
        if (r_lcnt == IW'(N-1)) r_state <= CALC;
      end
      if (w_issue) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_r;
        r_out_idx   <= r_opcnt;
        r_out_ovf   <= w_ovf;
        r_opcnt     <= r_opcnt + 1'b1;
        if (r_opcnt == IW'(N-1)) r_state <= DRAIN;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (r_state == DRAIN && out_ready) r_state <= LOAD;
    end
  end
endmodule
